// File: rtl/m_text_arb.sv
// rtl/m_text_arb.sv - two-requester round-robin arbiter writing strings onto a text-layer register bus
// Optional colour write before the address write when M_TEXT_ARB_COLOR_EN is defined.
module m_text_arb #(
    parameter int BASE = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic [6:0] ADDR_A,
    input  logic [6:0] ADDR_B,
    input  logic [6:0] LEN_A,
    input  logic [6:0] LEN_B,
    input  logic [5:0] COL_A,
    input  logic [5:0] COL_B,
    input  logic       CH_VALID_A,
    input  logic       CH_VALID_B,
    input  logic [6:0] CH_A,
    input  logic [6:0] CH_B,
    output logic       CH_READY_A,
    output logic       CH_READY_B,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic       DONE_A,
    output logic       DONE_B,
    output logic       BUSY,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe
);

    typedef enum logic [3:0] {
        IDLE,
`ifdef M_TEXT_ARB_COLOR_EN
        COL_SETUP, COL_STB, COL_HOLD,
`endif
        ADR_SETUP, ADR_STB, ADR_HOLD,
        WAIT_CH,
        DAT_SETUP, DAT_STB, DAT_HOLD,
        FIN
    } state_t;

    localparam logic [7:0] P_ADR  = 8'(BASE);
    localparam logic [7:0] P_CHR  = 8'(BASE + 3);

    state_t     state, state_nxt;
    logic       sel, sel_nxt;          // 0 = A granted, 1 = B granted
    logic       last_b, last_nxt;      // last served was B
    logic [6:0] rem, rem_nxt;
    logic [6:0] addr, addr_nxt;
    logic [6:0] ch, ch_nxt;
    logic [7:0] port_nxt, out_nxt;

`ifdef M_TEXT_ARB_COLOR_EN
    localparam logic [7:0] P_COLA = 8'(BASE + 1);
    localparam logic [7:0] P_COLB = 8'(BASE + 2);
    logic [5:0] col, col_nxt;
`else
    wire unused_col = ^{COL_A, COL_B};
`endif

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last_b;
        rem_nxt   = rem;
        addr_nxt  = addr;
        ch_nxt    = ch;
`ifdef M_TEXT_ARB_COLOR_EN
        col_nxt   = col;
`endif
        case (state)
            IDLE: if (REQ_A || REQ_B) begin
                // B wins only if A is absent or A was served last
                sel_nxt  = REQ_B && (!REQ_A || !last_b);
                addr_nxt = sel_nxt ? ADDR_B : ADDR_A;
                rem_nxt  = sel_nxt ? LEN_B : LEN_A;
`ifdef M_TEXT_ARB_COLOR_EN
                col_nxt   = sel_nxt ? COL_B : COL_A;
                state_nxt = COL_SETUP;
`else
                state_nxt = ADR_SETUP;
`endif
            end
`ifdef M_TEXT_ARB_COLOR_EN
            COL_SETUP: state_nxt = COL_STB;
            COL_STB:   state_nxt = COL_HOLD;
            COL_HOLD:  state_nxt = ADR_SETUP;
`endif
            ADR_SETUP: state_nxt = ADR_STB;
            ADR_STB:   state_nxt = ADR_HOLD;
            ADR_HOLD:  state_nxt = (rem == 7'd0) ? FIN : WAIT_CH;
            WAIT_CH: if (sel ? CH_VALID_B : CH_VALID_A) begin
                ch_nxt    = sel ? CH_B : CH_A;
                state_nxt = DAT_SETUP;
            end
            DAT_SETUP: state_nxt = DAT_STB;
            DAT_STB:   state_nxt = DAT_HOLD;
            DAT_HOLD: begin
                rem_nxt   = rem - 7'd1;
                state_nxt = (rem == 7'd1) ? FIN : WAIT_CH;
            end
            FIN: begin
                last_nxt  = sel;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Bus outputs are registered from the next state so they align with it
        port_nxt = 8'd0;
        out_nxt  = 8'd0;
        case (state_nxt)
`ifdef M_TEXT_ARB_COLOR_EN
            COL_SETUP, COL_STB, COL_HOLD: begin
                port_nxt = sel_nxt ? P_COLB : P_COLA;
                out_nxt  = {2'b00, col_nxt};
            end
`endif
            ADR_SETUP, ADR_STB, ADR_HOLD: begin
                port_nxt = P_ADR;
                out_nxt  = {1'b0, addr_nxt};
            end
            DAT_SETUP, DAT_STB, DAT_HOLD: begin
                port_nxt = P_CHR;
                out_nxt  = {1'b0, ch_nxt};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            sel          <= 1'b0;
            last_b       <= 1'b1;
            rem          <= 7'd0;
            addr         <= 7'd0;
            ch           <= 7'd0;
`ifdef M_TEXT_ARB_COLOR_EN
            col          <= 6'd0;
`endif
            port_id      <= 8'd0;
            out_port     <= 8'd0;
            write_strobe <= 1'b0;
            GNT_A        <= 1'b0;
            GNT_B        <= 1'b0;
            CH_READY_A   <= 1'b0;
            CH_READY_B   <= 1'b0;
            DONE_A       <= 1'b0;
            DONE_B       <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            last_b       <= last_nxt;
            rem          <= rem_nxt;
            addr         <= addr_nxt;
            ch           <= ch_nxt;
`ifdef M_TEXT_ARB_COLOR_EN
            col          <= col_nxt;
            write_strobe <= (state_nxt == ADR_STB) || (state_nxt == DAT_STB) || (state_nxt == COL_STB);
`else
            write_strobe <= (state_nxt == ADR_STB) || (state_nxt == DAT_STB);
`endif
            port_id      <= port_nxt;
            out_port     <= out_nxt;
            GNT_A        <= (state_nxt != IDLE) && !sel_nxt;
            GNT_B        <= (state_nxt != IDLE) && sel_nxt;
            CH_READY_A   <= (state_nxt == WAIT_CH) && !sel_nxt;
            CH_READY_B   <= (state_nxt == WAIT_CH) && sel_nxt;
            DONE_A       <= (state_nxt == FIN) && !sel_nxt;
            DONE_B       <= (state_nxt == FIN) && sel_nxt;
            BUSY         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_m_text_arb.sv
// tb/tb_m_text_arb.sv - directed table-driven bench for m_text_arb
module tb_m_text_arb;

    localparam int TB_BASE = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_A = 0, REQ_B = 0;
    logic [6:0] ADDR_A = 0, ADDR_B = 0, LEN_A = 0, LEN_B = 0;
    logic [5:0] COL_A = 0, COL_B = 0;
    logic       CH_VALID_A = 0, CH_VALID_B = 0;
    logic [6:0] CH_A = 0, CH_B = 0;
    logic       CH_READY_A, CH_READY_B, GNT_A, GNT_B, DONE_A, DONE_B, BUSY;
    logic [7:0] port_id, out_port;
    logic       write_strobe;

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    m_text_arb #(.BASE(TB_BASE)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
        .LEN_A(LEN_A), .LEN_B(LEN_B),
        .COL_A(COL_A), .COL_B(COL_B),
        .CH_VALID_A(CH_VALID_A), .CH_VALID_B(CH_VALID_B),
        .CH_A(CH_A), .CH_B(CH_B),
        .CH_READY_A(CH_READY_A), .CH_READY_B(CH_READY_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B),
        .DONE_A(DONE_A), .DONE_B(DONE_B), .BUSY(BUSY),
        .port_id(port_id), .out_port(out_port), .write_strobe(write_strobe)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (GNT_A && GNT_B) overlap++;

    typedef struct {
        logic       req_a;
        logic       vld;
        logic [6:0] ch;
        logic       stb;
        logic [7:0] port;
        logic [7:0] outp;
        logic       gnt;
        logic       rdy;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic r, logic v, logic [6:0] c, logic s, logic [7:0] p,
                                logic [7:0] o, logic g, logic y, logic d, logic b);
        vec_t t;
        t.req_a = r; t.vld = v; t.ch = c; t.stb = s; t.port = p;
        t.outp = o; t.gnt = g; t.rdy = y; t.done = d; t.busy = b;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic cond(input int which);
        case (which)
            0: return GNT_A || GNT_B;
            1: return DONE_A || DONE_B;
            2: return write_strobe;
            default: return CH_READY_A;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        int n = 0;
        step();
        while (!cond(which) && n < 60) begin
            step();
            n++;
        end
        if (!cond(which)) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        RST = 1;
        REQ_A = 0; REQ_B = 0; CH_VALID_A = 0; CH_VALID_B = 0;
        step();
        step();
        chk("rst_port", port_id, 0);
        chk("rst_out", out_port, 0);
        chk("rst_stb", write_strobe, 0);
        chk("rst_gnt", {GNT_A, GNT_B}, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_rdy_done", {CH_READY_A, CH_READY_B, DONE_A, DONE_B}, 0);
        RST = 0;
        step();
    endtask

    initial begin
        int stb_cnt, rdy_cnt, done_cnt, n;
        logic [7:0] p_seen, o_seen;

        do_reset();

`ifdef M_TEXT_ARB_COLOR_EN
        // Colour write precedes the address write for B
        REQ_B = 1; COL_B = 6'h2A; ADDR_B = 7'd9; LEN_B = 0;
        wait_for(2, "col_stb");
        REQ_B = 0;
        chk("col_port", port_id, TB_BASE + 2);
        chk("col_out", out_port, 8'h2A);
        wait_for(2, "col_adr_stb");
        chk("col_adr_port", port_id, TB_BASE);
        chk("col_adr_out", out_port, 9);
        wait_for(1, "col_done");
        chk("col_done_b", DONE_B, 1);
        step();
`else
        // Two-character string from A, one row per cycle after the grant edge
        tbl[0]  = mk(1, 1, 7'h41, 0, 8'(TB_BASE),     8'h05, 1, 0, 0, 1);
        tbl[1]  = mk(0, 1, 7'h41, 1, 8'(TB_BASE),     8'h05, 1, 0, 0, 1);
        tbl[2]  = mk(0, 1, 7'h41, 0, 8'(TB_BASE),     8'h05, 1, 0, 0, 1);
        tbl[3]  = mk(0, 1, 7'h41, 0, 8'h00,           8'h00, 1, 1, 0, 1);
        tbl[4]  = mk(0, 1, 7'h41, 0, 8'(TB_BASE + 3), 8'h41, 1, 0, 0, 1);
        tbl[5]  = mk(0, 1, 7'h42, 1, 8'(TB_BASE + 3), 8'h41, 1, 0, 0, 1);
        tbl[6]  = mk(0, 1, 7'h42, 0, 8'(TB_BASE + 3), 8'h41, 1, 0, 0, 1);
        tbl[7]  = mk(0, 1, 7'h42, 0, 8'h00,           8'h00, 1, 1, 0, 1);
        tbl[8]  = mk(0, 1, 7'h42, 0, 8'(TB_BASE + 3), 8'h42, 1, 0, 0, 1);
        tbl[9]  = mk(0, 1, 7'h42, 1, 8'(TB_BASE + 3), 8'h42, 1, 0, 0, 1);
        tbl[10] = mk(0, 1, 7'h42, 0, 8'(TB_BASE + 3), 8'h42, 1, 0, 0, 1);
        tbl[11] = mk(0, 1, 7'h42, 0, 8'h00,           8'h00, 1, 0, 1, 1);
        tbl[12] = mk(0, 0, 7'h42, 0, 8'h00,           8'h00, 0, 0, 0, 0);
        ADDR_A = 7'd5; LEN_A = 7'd2;
        for (int i = 0; i < 13; i++) begin
            REQ_A = tbl[i].req_a; CH_VALID_A = tbl[i].vld; CH_A = tbl[i].ch;
            step();
            chk($sformatf("v%0d_stb", i + 1), write_strobe, tbl[i].stb);
            chk($sformatf("v%0d_port", i + 1), port_id, tbl[i].port);
            chk($sformatf("v%0d_out", i + 1), out_port, tbl[i].outp);
            chk($sformatf("v%0d_gnt", i + 1), GNT_A, tbl[i].gnt);
            chk($sformatf("v%0d_rdy", i + 1), CH_READY_A, tbl[i].rdy);
            chk($sformatf("v%0d_done", i + 1), DONE_A, tbl[i].done);
            chk($sformatf("v%0d_busy", i + 1), BUSY, tbl[i].busy);
        end

        // Zero-length string from B: one address write then done
        do_reset();
        REQ_B = 1; ADDR_B = 7'h7F; LEN_B = 0;
        stb_cnt = 0; rdy_cnt = 0; done_cnt = 0; p_seen = 0; o_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            REQ_B = 0;
            if (write_strobe) begin
                stb_cnt++; p_seen = port_id; o_seen = out_port;
            end
            if (CH_READY_B) rdy_cnt++;
            if (DONE_B) done_cnt++;
        end
        chk("len0_strobes", stb_cnt, 1);
        chk("len0_port", p_seen, TB_BASE);
        chk("len0_out", o_seen, 8'h7F);
        chk("len0_done", done_cnt, 1);
        chk("len0_ready", rdy_cnt, 0);

        // Character stall in WAIT_CH
        do_reset();
        REQ_A = 1; ADDR_A = 7'd3; LEN_A = 7'd1; CH_VALID_A = 0;
        wait_for(3, "stall_ready");
        REQ_A = 0;
        stb_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (write_strobe) stb_cnt++;
            if (CH_READY_A) rdy_cnt++;
        end
        chk("stall_strobes", stb_cnt, 0);
        chk("stall_ready_cnt", rdy_cnt, 10);
        CH_VALID_A = 1; CH_A = 7'h55;
        wait_for(2, "stall_resume");
        CH_VALID_A = 0;
        chk("stall_port", port_id, TB_BASE + 3);
        chk("stall_out", out_port, 8'h55);
        wait_for(1, "stall_done");
        chk("stall_done_a", DONE_A, 1);

        // Reset in the middle of a character strobe
        do_reset();
        REQ_A = 1; ADDR_A = 7'h10; LEN_A = 7'd3; CH_VALID_A = 1; CH_A = 7'h30;
        n = 0;
        step();
        REQ_A = 0;
        while (!(write_strobe && port_id == 8'(TB_BASE + 3)) && n < 40) begin
            step();
            n++;
        end
        chk("rststb_reached", write_strobe && port_id == 8'(TB_BASE + 3), 1);
        RST = 1;
        #1;
        chk("rststb_stb", write_strobe, 0);
        chk("rststb_gnt", GNT_A, 0);
        chk("rststb_busy", BUSY, 0);
        step();
        RST = 0;
        stb_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (write_strobe) stb_cnt++;
        end
        chk("rststb_quiet", stb_cnt, 0);
        REQ_A = 1;
        step();
        chk("rststb_regrant", GNT_A, 1);
        REQ_A = 0; CH_VALID_A = 0;
`endif

        // Round robin with both requesting continuously
        do_reset();
        LEN_A = 0; LEN_B = 0; REQ_A = 1; REQ_B = 1;
        overlap = 0;
        for (int i = 0; i < 4; i++) begin
            wait_for(0, "rr_grant");
            chk($sformatf("rr%0d_who", i), {GNT_A, GNT_B}, (i % 2) ? 2'b01 : 2'b10);
            wait_for(1, "rr_done");
        end
        REQ_A = 0; REQ_B = 0;
        chk("rr_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m_text_arb.md
M_TEXT_ARB -- requirements
Module: m_text_arb

Interface
REQ-001 SHALL have parameter BASE, default 0, port_id base of the target text-layer register block (BASE+0 address, +1 colour A, +2 colour B, +3 character).
REQ-002 SHALL have CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have REQ_A, REQ_B  input  1 each  level request to write one string.
REQ-005 SHALL have ADDR_A, ADDR_B  input  7 each  start cell, sampled at grant.
REQ-006 SHALL have LEN_A, LEN_B  input  7 each  character count, 0..127, sampled at grant.
REQ-007 SHALL have COL_A, COL_B  input  6 each  colour, sampled at grant; used only with M_TEXT_ARB_COLOR_EN.
REQ-008 SHALL have CH_VALID_A/B  input  1;  CH_A/B  input  7;  CH_READY_A/B  output  1: per-requester character handshake.
REQ-009 SHALL have GNT_A, GNT_B  output  1  high for the whole service of that requester.
REQ-010 SHALL have DONE_A, DONE_B  output  1  one-cycle pulse at service end; BUSY  output  1  state != IDLE.
REQ-011 SHALL have port_id  output  8,  out_port  output  8,  write_strobe  output  1: target write bus.

Function
REQ-012 States SHALL be IDLE, [COL_SETUP, COL_STB, COL_HOLD], ADR_SETUP, ADR_STB, ADR_HOLD, WAIT_CH, DAT_SETUP, DAT_STB, DAT_HOLD, FIN.
REQ-013 Each bus write SHALL take exactly 3 cycles: SETUP (port_id/out_port valid, strobe 0), STB (strobe 1, bus unchanged), HOLD (strobe 0, bus unchanged).
REQ-014 write_strobe SHALL be a registered output, high only in *_STB states.
REQ-015 In IDLE with any REQ high, SHALL grant at next edge; both high: grant the requester not served last (round-robin, A preferred after reset).
REQ-016 On grant SHALL latch ADDR, LEN, COL of the winner into a remaining counter and registers; GNT_x high from the first SETUP cycle through FIN.
REQ-017 Address write SHALL drive port_id=BASE+0, out_port={1'b0,ADDR}.
REQ-018 After ADR_HOLD: LEN remaining 0 -> FIN; else WAIT_CH.
REQ-019 In WAIT_CH, CH_READY_x of the granted requester SHALL be 1 (all other cycles 0); on CH_VALID_x&&CH_READY_x latch CH_x, go DAT_SETUP; no valid -> stay indefinitely.
REQ-020 Character write SHALL drive port_id=BASE+3, out_port={1'b0,char}; remaining decrements in DAT_HOLD; remaining 0 -> FIN else WAIT_CH.
REQ-021 Cell address wrap (127->0) SHALL be left to the target's auto-increment; block imposes no limit.
REQ-022 FIN SHALL pulse DONE_x one cycle, drop GNT_x, record last-served, return to IDLE next edge; REQ re-sampled only in IDLE.
REQ-023 REQ or inputs changing during service SHALL not affect the current string.
REQ-024 Idle bus: port_id=0, out_port=0, write_strobe=0.

Reset
REQ-025 RST SHALL asynchronously force IDLE, all outputs 0, counters 0, last-served=B.
REQ-026 RST during *_STB SHALL drop write_strobe immediately; no further rising strobe edge until a new grant.

Configuration
REQ-027 With M_TEXT_ARB_COLOR_EN defined, after grant SHALL first write colour: port_id=BASE+1 (A) or BASE+2 (B), out_port={2'b0,COL}, then the address write; undefined, COL_* states absent, grant goes directly to ADR_SETUP, COL inputs ignored.

Verification
REQ-028 REQ_A=1, ADDR_A=5, LEN_A=2, chars 0x41,0x42 always valid, no COLOR_EN -> strobes at cycles 2,6,10 after grant edge with (0,5),(3,0x41),(3,0x42); DONE_A one pulse.
REQ-029 REQ_A and REQ_B both high continuously after reset -> grants A,B,A,B alternate; GNT never overlapping.
REQ-030 LEN_B=0 -> single address write then DONE_B; CH_READY_B never high.
REQ-031 CH_VALID_A low 10 cycles in WAIT_CH -> write_strobe stays 0, CH_READY_A stays 1, resumes on valid.
REQ-032 RST asserted in DAT_STB -> write_strobe, GNT, BUSY 0 same cycle; no strobe until next REQ.
REQ-033 COLOR_EN, REQ_B, COL_B=0x2A -> first write (BASE+2,0x2A), then address write.
